// File: rtl/digit_classifier_pkg.sv
// Shared network constants and the classifier state encoding.
package digit_classifier_pkg;

  localparam int NET_DATA_WIDTH  = 32;
  localparam int Q_FRAC_BITS     = 16;
  localparam int DEF_NUM_CLASSES = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/digit_classifier_score_compare.sv
// Combinational signed comparator: candidate versus current best.
module score_compare #(
  parameter int DATA_WIDTH = 32
) (
  input  logic signed [DATA_WIDTH-1:0] cand,
  input  logic signed [DATA_WIDTH-1:0] best,
  output logic                         greater,
  output logic                         equal
);

  assign greater = cand > best;
  assign equal   = cand == best;

endmodule

// File: rtl/digit_classifier.sv
// Argmax over the output-layer scores, scanning one class per cycle.
module digit_classifier
  import digit_classifier_pkg::*;
#(
  parameter int NUM_CLASSES = DEF_NUM_CLASSES,
  parameter int DATA_WIDTH  = NET_DATA_WIDTH,
  parameter int IDX_WIDTH   = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [NUM_CLASSES*DATA_WIDTH-1:0] scores,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [IDX_WIDTH-1:0]              digit,
  output logic [DATA_WIDTH-1:0]             max_score,
  output logic                              tie,
  output logic [15:0]                       class_count
);

  state_t                            state_q, state_d;
  logic [NUM_CLASSES*DATA_WIDTH-1:0] cap_q;
  logic [IDX_WIDTH-1:0]              idx_q;
  logic [IDX_WIDTH-1:0]              best_idx_q;
  logic signed [DATA_WIDTH-1:0]      best_q;
  logic signed [DATA_WIDTH-1:0]      cur_score;
  logic                              tie_q;
  logic [15:0]                       count_q;
  logic                              last;
  logic                              gt;
  logic                              eq;

  // Select the captured score under the scan index; never reads the live input.
  always_comb begin
    cur_score = '0;
    for (int k = 0; k < NUM_CLASSES; k++) begin
      if (idx_q == IDX_WIDTH'(k)) cur_score = cap_q[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign last = (idx_q == IDX_WIDTH'(NUM_CLASSES - 1));

  score_compare #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_cmp (
    .cand   (cur_score),
    .best   (best_q),
    .greater(gt),
    .equal  (eq)
  );

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = (NUM_CLASSES == 1) ? ST_DONE : ST_SCAN;
      end
      ST_SCAN: begin
        if (last) state_d = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cap_q      <= '0;
      idx_q      <= '0;
      best_q     <= '0;
      best_idx_q <= '0;
      tie_q      <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            cap_q      <= scores;
            best_q     <= scores[DATA_WIDTH-1:0];
            best_idx_q <= '0;
            tie_q      <= 1'b0;
            idx_q      <= IDX_WIDTH'(1);
          end
        end
        ST_SCAN: begin
          // Strict greater-than keeps the lowest index on equal scores.
          if (gt) begin
            best_q     <= cur_score;
            best_idx_q <= idx_q;
            tie_q      <= 1'b0;
          end else if (eq) begin
            tie_q <= 1'b1;
          end
          if (!last) idx_q <= idx_q + 1'b1;
        end
        ST_DONE: begin
          if (out_ready) count_q <= count_q + 16'd1;
        end
        default: ;
      endcase
    end
  end

  assign digit       = best_idx_q;
  assign max_score   = best_q;
  assign tie         = tie_q;
  assign class_count = count_q;

endmodule

// File: tb/tb_digit_classifier.sv
// Bench for digit_classifier: directed table, corner sequences, random vectors vs argmax model.
module tb_digit_classifier;

  localparam int N  = 10;
  localparam int DW = 32;
  localparam int IW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic            in_valid, in_ready, out_valid, out_ready, tie;
  logic [N*DW-1:0] scores;
  logic [IW-1:0]   digit;
  logic [DW-1:0]   max_score;
  logic [15:0]     class_count;

  logic            in_valid1, in_ready1, out_valid1, out_ready1, tie1;
  logic [DW-1:0]   scores1, max_score1;
  logic [IW-1:0]   digit1;
  logic [15:0]     class_count1;

  digit_classifier #(.NUM_CLASSES(N), .DATA_WIDTH(DW), .IDX_WIDTH(IW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .scores(scores),
    .out_valid(out_valid), .out_ready(out_ready), .digit(digit), .max_score(max_score),
    .tie(tie), .class_count(class_count)
  );

  digit_classifier #(.NUM_CLASSES(1), .DATA_WIDTH(DW), .IDX_WIDTH(IW)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .scores(scores1),
    .out_valid(out_valid1), .out_ready(out_ready1), .digit(digit1), .max_score(max_score1),
    .tie(tie1), .class_count(class_count1)
  );

  typedef struct {
    logic [N*DW-1:0] v;
    logic [IW-1:0]   dig;
    logic [DW-1:0]   mx;
    logic            t;
  } vec_t;

  vec_t tbl[4];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic signed [DW-1:0] sc(input logic [N*DW-1:0] v, input int k);
    return v[k*DW +: DW];
  endfunction

  // Argmax by definition: find the maximum value, then the first index holding it.
  task automatic model(input logic [N*DW-1:0] v, output logic [IW-1:0] d,
                       output logic [DW-1:0] m, output logic t);
    logic signed [DW-1:0] mx;
    int cnt;
    mx = sc(v, 0);
    for (int k = 1; k < N; k++) if (sc(v, k) > mx) mx = sc(v, k);
    cnt = 0;
    d   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (sc(v, k) == mx) begin
        d = IW'(k);
        cnt++;
      end
    end
    m = mx;
    t = (cnt > 1);
  endtask

  // Caller sits 1 time unit after a rising edge; returns in the same phase.
  task automatic run_vec(input logic [N*DW-1:0] v, output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL idle_wait: in_ready stayed 0 for %0d cycles", w);
    end
    scores   = v;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    scores   = ~v;
    lat = 1;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [N*DW-1:0] v;
    logic [IW-1:0]   ed;
    logic [DW-1:0]   em;
    logic            et;
    int              lat;
    int              exp_count;
    int              x;
    logic [31:0]     r;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; scores = '0;
    in_valid1 = 1'b0; out_ready1 = 1'b0; scores1 = '0;
    exp_count = 0;

    tbl[0].v = '0; tbl[0].v[7*DW +: DW] = 32'h0003_0000;
    tbl[0].dig = 4'd7; tbl[0].mx = 32'h0003_0000; tbl[0].t = 1'b0;
    for (int k = 0; k < N; k++) tbl[1].v[k*DW +: DW] = 32'(-(k + 1) * 65536);
    tbl[1].dig = 4'd0; tbl[1].mx = 32'hFFFF_0000; tbl[1].t = 1'b0;
    tbl[2].v = '0; tbl[2].v[2*DW +: DW] = 32'h0005_0000; tbl[2].v[5*DW +: DW] = 32'h0005_0000;
    tbl[2].dig = 4'd2; tbl[2].mx = 32'h0005_0000; tbl[2].t = 1'b1;
    tbl[3].v = tbl[2].v; tbl[3].v[8*DW +: DW] = 32'h0006_0000;
    tbl[3].dig = 4'd8; tbl[3].mx = 32'h0006_0000; tbl[3].t = 1'b0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_digit", 32'(digit), 32'd0);
    check("rst_max", max_score, 32'd0);
    check("rst_tie", 32'(tie), 32'd0);
    check("rst_count", 32'(class_count), 32'd0);

    for (int i = 0; i < 4; i++) begin
      run_vec(tbl[i].v, lat);
      check($sformatf("tbl%0d_latency", i), 32'(lat), 32'(N));
      check($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'd0);
      check($sformatf("tbl%0d_digit", i), 32'(digit), 32'(tbl[i].dig));
      check($sformatf("tbl%0d_max", i), max_score, tbl[i].mx);
      check($sformatf("tbl%0d_tie", i), 32'(tie), 32'(tbl[i].t));
      release_result();
      exp_count++;
      check($sformatf("tbl%0d_count", i), 32'(class_count), 32'(exp_count));
      check($sformatf("tbl%0d_back_idle", i), 32'(in_ready), 32'd1);
    end

    // Hold the result in DONE while upstream keeps toggling.
    v = tbl[0].v;
    v[3*DW +: DW] = 32'h0004_0000;
    v[9*DW +: DW] = 32'h0004_0000;
    model(v, ed, em, et);
    run_vec(v, lat);
    for (int c = 0; c < 20; c++) begin
      in_valid = c[0];
      for (int k = 0; k < N; k++) scores[k*DW +: DW] = $urandom;
      @(posedge clk); #1;
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_digit", 32'(digit), 32'(ed));
      check("hold_max", max_score, em);
      check("hold_tie", 32'(tie), 32'(et));
    end
    check("hold_count_before", 32'(class_count), 32'(exp_count));
    in_valid = 1'b0;
    release_result();
    exp_count++;
    check("hold_count_after", 32'(class_count), 32'(exp_count));
    check("hold_idle", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    check("hold_no_capture", 32'(in_ready), 32'd1);

    // Reset while the scan index sits at 4.
    v = '0;
    v[2*DW +: DW] = 32'h0009_0000;
    scores   = v;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("scan_digit_before_rst", 32'(digit), 32'd2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_digit", 32'(digit), 32'd0);
    check("midrst_count", 32'(class_count), 32'd0);
    exp_count = 0;
    run_vec(tbl[0].v, lat);
    check("post_rst_latency", 32'(lat), 32'(N));
    check("post_rst_digit", 32'(digit), 32'(tbl[0].dig));
    release_result();
    exp_count++;
    check("post_rst_count", 32'(class_count), 32'(exp_count));

    // Back-to-back random vectors with the consumer always ready.
    out_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      for (int k = 0; k < N; k++) begin
        r = $urandom;
        if (r[3]) begin
          x = int'($urandom_range(0, 6)) - 3;
          v[k*DW +: DW] = 32'(x * 65536);
        end else begin
          v[k*DW +: DW] = $urandom;
        end
      end
      model(v, ed, em, et);
      run_vec(v, lat);
      check($sformatf("rnd%0d_latency", i), 32'(lat), 32'(N));
      check($sformatf("rnd%0d_digit", i), 32'(digit), 32'(ed));
      check($sformatf("rnd%0d_max", i), max_score, em);
      check($sformatf("rnd%0d_tie", i), 32'(tie), 32'(et));
      exp_count++;
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("rnd_count", 32'(class_count), 32'(exp_count));

    // Counter wrap from 0xFFFF.
    force dut.count_q = 16'hFFFF;
    @(posedge clk); #1;
    release dut.count_q;
    check("preload_count", 32'(class_count), 32'h0000_FFFF);
    run_vec(tbl[2].v, lat);
    release_result();
    check("wrap_count", 32'(class_count), 32'd0);

    // Single-class instance.
    scores1   = 32'h8000_0000;
    in_valid1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    scores1   = 32'h0001_0000;
    check("n1_out_valid", 32'(out_valid1), 32'd1);
    check("n1_in_ready", 32'(in_ready1), 32'd0);
    check("n1_digit", 32'(digit1), 32'd0);
    check("n1_max", max_score1, 32'h8000_0000);
    check("n1_tie", 32'(tie1), 32'd0);
    out_ready1 = 1'b1;
    @(posedge clk); #1;
    out_ready1 = 1'b0;
    check("n1_count", 32'(class_count1), 32'd1);
    check("n1_idle", 32'(in_ready1), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
